// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data RAM arbiter.
//   owner_t     : which requester a read slot belongs to (CPU or DMA)
//   rd_tag_t    : one stage of the read-owner pipeline {valid, owner}
//   *_DEF       : default AW/DW/RD_LAT/MAX_WAIT values
//   wait_cnt_w  : width of a counter that must hold 0..max_wait
package mem_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam int AW_DEF       = 10;
  localparam int DW_DEF       = 32;
  localparam int RD_LAT_DEF   = 1;
  localparam int MAX_WAIT_DEF = 64;

  function automatic int wait_cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-stage shift register of read-owner tags. A tag enters at stage 0
// in the cycle the RAM sees the read address and leaves the last stage in
// the cycle the RAM returns that read's data.
// Ports:
//   CLK     : system clock, rising edge
//   RST     : asynchronous active-low clear (drops every in-flight tag)
//   tag_in  : tag for the access issued this cycle
//   tag_out : tag matching the data currently on the RAM read bus
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic    CLK,
  input  logic    RST,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [RD_LAT];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data RAM between the CPU data port and a DMA/debug
// requester. The CPU cannot stall, so any CPU access owns the RAM in the
// cycle it is presented; the DMA side only gets the RAM on cycles the CPU
// leaves idle.
// Ports:
//   CLK, RST                 : clock (rising edge), async active-low reset
//   cpu_addr_i/wdata/we/re/byte : CPU data port (address bits [AW-1:0] used)
//   cpu_rdata_o              : RAM read data, passed straight through
//   dma_req_i, dma_addr_i, dma_wdata_i, dma_we_i, dma_byte_i : DMA request
//   dma_gnt_o                : DMA access accepted this cycle
//   dma_rvalid_o, dma_rdata_o: DMA read response, RD_LAT cycles after grant
//   dma_starved_o            : sticky, DMA denied MAX_WAIT cycles in a row
//   dma_clr_i                : clears dma_starved_o and the wait counter
//   ram_addr_o/wdata/we/byte, ram_rdata_i : data RAM port
//
// DMA handshake: the request is a valid/ready pair with dma_req_i as valid
// and dma_gnt_o as ready. A transfer happens in exactly the cycles where
// both are high. While dma_req_i is high and dma_gnt_o is low the requester
// holds addr/wdata/we/byte unchanged. A granted write is done that cycle; a
// granted read returns one dma_rvalid_o pulse RD_LAT cycles later, and
// multiple reads in flight return in issue order.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  input  logic          cpu_we_i,
  input  logic          cpu_re_i,
  input  logic          cpu_byte_i,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          dma_req_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  input  logic          dma_we_i,
  input  logic          dma_byte_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_starved_o,
  input  logic          dma_clr_i,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          ram_we_o,
  output logic          ram_byte_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam int            CW      = wait_cnt_w(MAX_WAIT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic          cpu_act;
  rd_tag_t       tag_in;
  rd_tag_t       tag_out;
  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_nxt;
  logic          unused_cpu_addr_hi;

  // Upper CPU address bits select nothing inside this RAM.
  assign unused_cpu_addr_hi = ^cpu_addr_i[31:AW];

  assign cpu_act = cpu_we_i | cpu_re_i;

  // RST is folded in so no grant can leak out while the block is in reset.
  assign dma_gnt_o = dma_req_i & ~cpu_act & RST;

  // RAM port mux. With neither side active the CPU fields still drive the
  // bus (address follows the CPU) but the write enable stays low.
  always_comb begin
    ram_addr_o  = cpu_addr_i[AW-1:0];
    ram_wdata_o = cpu_wdata_i;
    ram_we_o    = cpu_we_i & RST;
    ram_byte_o  = cpu_byte_i;
    if (dma_gnt_o) begin
      ram_addr_o  = dma_addr_i;
      ram_wdata_o = dma_wdata_i;
      ram_we_o    = dma_we_i;
      ram_byte_o  = dma_byte_i;
    end
  end

  // Tag every read with its owner so the response can be steered when the
  // RAM returns data. A DMA grant implies the CPU is idle, so the two
  // branches never compete.
  always_comb begin
    tag_in = '0;
    if (dma_gnt_o && !dma_we_i) begin
      tag_in.valid = 1'b1;
      tag_in.owner = OWN_DMA;
    end else if (cpu_re_i) begin
      tag_in.valid = 1'b1;
      tag_in.owner = OWN_CPU;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign dma_rvalid_o = tag_out.valid & (tag_out.owner == OWN_DMA);
  assign dma_rdata_o  = ram_rdata_i;
  assign cpu_rdata_o  = ram_rdata_i;

  // Consecutive-denial counter: restarts on grant, holds while the DMA side
  // is quiet, saturates at MAX_WAIT.
  always_comb begin
    wait_cnt_nxt = wait_cnt_q;
    if (dma_gnt_o) begin
      wait_cnt_nxt = '0;
    end else if (dma_req_i && (wait_cnt_q != MAX_CNT)) begin
      wait_cnt_nxt = wait_cnt_q + CW'(1);
    end
  end

  // The flag is set on the edge where the counter reaches MAX_WAIT, so it is
  // visible right after the MAX_WAIT-th denied cycle. Clear beats set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_q    <= '0;
      dma_starved_o <= 1'b0;
    end else if (dma_clr_i) begin
      wait_cnt_q    <= '0;
      dma_starved_o <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_nxt;
      if (wait_cnt_nxt == MAX_CNT) dma_starved_o <= 1'b1;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data RAM (10-bit word address, 32-bit data, write enable, byte mode) between the CPU data port and a secondary DMA/debug requester.
- The CPU has no stall input, so it has absolute priority: every CPU access is forwarded in the same cycle.
- The DMA requester uses a req/gnt handshake and receives read data tagged by a read-latency pipeline.
- Sits between the CPU, the DMA requester and the data RAM instance at the top level.

Parameters:
- AW, 10, RAM word-address width forwarded to the RAM.
- DW, 32, data width.
- RD_LAT, 1, cycles from address presentation to valid ram_rdata_i (1..3).
- MAX_WAIT, 64, consecutive denied DMA request cycles before dma_starved_o is set.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- cpu_addr_i  in  32  CPU data address; bits [AW-1:0] used.
- cpu_wdata_i  in  DW  CPU write data.
- cpu_we_i  in  1  CPU write strobe.
- cpu_re_i  in  1  CPU read strobe.
- cpu_byte_i  in  1  CPU byte mode.
- cpu_rdata_o  out  DW  read data to CPU.
- dma_req_i  in  1  DMA request; addr/data/we/byte stable while req high and gnt low.
- dma_addr_i  in  AW  DMA word address.
- dma_wdata_i  in  DW  DMA write data.
- dma_we_i  in  1  1 = write, 0 = read.
- dma_byte_i  in  1  DMA byte mode.
- dma_gnt_o  out  1  access accepted this cycle.
- dma_rvalid_o  out  1  dma_rdata_o valid (1-cycle pulse).
- dma_rdata_o  out  DW  read data to DMA.
- dma_starved_o  out  1  sticky starvation flag.
- dma_clr_i  in  1  clears dma_starved_o and the wait counter.
- ram_addr_o  out  AW  RAM address.
- ram_wdata_o  out  DW  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_byte_o  out  1  RAM byte mode.
- ram_rdata_i  in  DW  RAM read data.

Behaviour:
- cpu_act = cpu_we_i | cpu_re_i. dma_gnt_o = dma_req_i & ~cpu_act & RST (combinational).
- RAM mux (combinational):
  - if dma_gnt_o, ram_* are driven from dma_*;
  - else from cpu_* (address truncated to AW), with ram_we_o = cpu_we_i;
  - when idle (no cpu_act, no grant), ram_addr_o follows cpu_addr_i and ram_we_o = 0.
- Simultaneous CPU and DMA access: CPU wins; DMA stays pending and must hold its inputs; no grant that cycle.
- Read-owner pipeline: RD_LAT-deep shift register of {valid, owner}, shifted every cycle.
  - Stage 0 loads {1, DMA} on a granted DMA read, {1, CPU} on cpu_re_i, otherwise {0, x}.
  - dma_rvalid_o = last stage valid & owner == DMA; dma_rdata_o = ram_rdata_i.
  - cpu_rdata_o = ram_rdata_i unconditionally (CPU timing unchanged).
- DMA writes: complete on the granted cycle; no response.
- Back-to-back DMA grants are allowed every cycle; up to RD_LAT DMA reads can be in flight, and responses return in issue order.
- Wait counter: ceil(log2(MAX_WAIT+1)) bits.
  - Increments on each dma_req_i & ~dma_gnt_o cycle; clears on grant; saturates at MAX_WAIT.
  - Reaching MAX_WAIT sets dma_starved_o, which stays set until dma_clr_i (dma_clr_i has priority over set in the same cycle).
- Reset (RST low, asynchronous):
  - the pipeline is cleared, so pending DMA responses are discarded;
  - dma_rvalid_o = 0, dma_starved_o = 0, wait counter = 0;
  - dma_gnt_o = 0 and ram_we_o = 0 while in reset.
- Response latency: DMA read data arrives exactly RD_LAT cycles after the grant cycle.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef owner_t {OWN_CPU, OWN_DMA};
  - typedef rd_tag_t struct {valid, owner};
  - default AW/DW/RD_LAT constants.
- One sub-module, rd_tag_pipe: the RD_LAT-stage tag shift register with asynchronous clear.

Test Plan:
- DMA read with CPU idle, RD_LAT = 1, RAM[5] = 32'hDEAD_BEEF: req addr 5 → gnt the same cycle; dma_rvalid_o = 1 with dma_rdata_o = 32'hDEAD_BEEF one cycle later; cpu_rdata_o untouched.
- CPU write addr 7 data 42 while DMA requests write addr 7 data 99 → CPU written first, no DMA grant; the next idle cycle grants DMA; final RAM[7] = 99.
- CPU read and DMA read interleaved over 4 cycles → dma_rvalid_o pulses only for DMA-owned slots; CPU data unaffected.
- CPU active for 64 consecutive cycles with DMA requesting, MAX_WAIT = 64 → dma_starved_o rises after the 64th denied cycle and stays high; pulsing dma_clr_i clears it.
- RST low asserted one cycle after a granted DMA read → no dma_rvalid_o pulse; all outputs reset immediately.
- Three back-to-back DMA reads, RD_LAT = 3 → three rvalid pulses on consecutive cycles, in issue order, with correct data.
